// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode map, unit-select codes and FSM states shared by the ALU core and its divider
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_NOP  = 4'h8;
  localparam logic [3:0] OP_EQ   = 4'h9;
  localparam logic [3:0] OP_GT   = 4'hA;
  localparam logic [3:0] OP_LT   = 4'hB;
  localparam logic [3:0] OP_SHRA = 4'hC;
  localparam logic [3:0] OP_SHLA = 4'hD;
  localparam logic [3:0] OP_SHRB = 4'hE;
  localparam logic [3:0] OP_SHLB = 4'hF;
  localparam logic [1:0] UNIT_ARITH = 2'd0;
  localparam logic [1:0] UNIT_LOGIC = 2'd1;
  localparam logic [1:0] UNIT_CMP   = 2'd2;
  localparam logic [1:0] UNIT_SHIFT = 2'd3;
  typedef enum logic {IDLE, DIV} state_e;
  // One-hot {Arith, Logic, CMP, Shift} from the unit select bits
  function automatic logic [3:0] unit_flags(input logic [1:0] unit);
    return 4'b1000 >> unit;
  endfunction
endpackage

// File: rtl/alu_seq_div.sv
// alu_seq_div: iterative restoring divider, one quotient bit per cycle MSB first; remainder port with ALU_SEQ_REM_EN
module alu_seq_div #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic                  div0_o,
  output logic [DATA_WIDTH-1:0] quot_o
`ifdef ALU_SEQ_REM_EN
  ,
  output logic [DATA_WIDTH-1:0] rem_o
`endif
);
  localparam int CW = $clog2(DATA_WIDTH);
  logic                  busy_q, busy_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d, rem_nx;
  logic [DATA_WIDTH:0]   part;
  logic                  fits;
  // Trial subtraction of the divisor from the shifted partial remainder; quot_o/rem_o are the values after this cycle's step
  always_comb begin
    part   = {rem_q, quot_q[DATA_WIDTH-1]};
    fits   = part >= {1'b0, dvs_q};
    rem_nx = fits ? DATA_WIDTH'(part - {1'b0, dvs_q}) : part[DATA_WIDTH-1:0];
    quot_o = {quot_q[DATA_WIDTH-2:0], fits};
    done_o = busy_q && (cnt_q == CW'(DATA_WIDTH - 1));
    div0_o = ~|b_i;
    busy_d = start_i ? 1'b1 : done_o ? 1'b0 : busy_q;
    cnt_d  = start_i ? '0 : busy_q ? cnt_q + CW'(1) : cnt_q;
    quot_d = start_i ? a_i : busy_q ? quot_o : quot_q;
    rem_d  = start_i ? '0 : busy_q ? rem_nx : rem_q;
    dvs_d  = start_i ? b_i : dvs_q;
  end
`ifdef ALU_SEQ_REM_EN
  assign rem_o = rem_nx;
`endif
  // Divider state registers, cleared by reset so an interrupted division leaves nothing behind
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked 16-opcode ALU with registered result and multi-cycle divider; REM_OUT port with ALU_SEQ_REM_EN
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [FUN_WIDTH-1:0]  ALU_FUN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  Carry_OUT,
  output logic                  Arith_Flag,
  output logic                  Logic_Flag,
  output logic                  CMP_Flag,
  output logic                  Shift_Flag,
  output logic                  DIV0_Flag,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  BUSY
`ifdef ALU_SEQ_REM_EN
  ,
  output logic [DATA_WIDTH-1:0] REM_OUT
`endif
);
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d, alu_res, div_quot;
  logic [DATA_WIDTH:0]   sum;
  logic [3:0]            flags_q, flags_d;
  logic                  cy_q, cy_d, d0_q, d0_d, valid_q, valid_d;
  logic                  alu_cy, alu_d0, accept, div_start, div_done, div0;
`ifdef ALU_SEQ_REM_EN
  logic [DATA_WIDTH-1:0] rem_q, rem_d, alu_rem, div_rem;
`endif
  assign IN_READY  = (state_q == IDLE) && (!valid_q || OUT_READY);
  assign accept    = IN_VALID && IN_READY;
  assign div_start = accept && (ALU_FUN == OP_DIV) && !div0;
  assign RESULT    = result_q;
  assign Carry_OUT = cy_q;
  assign {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = flags_q;
  assign DIV0_Flag = d0_q;
  assign OUT_VALID = valid_q;
  assign BUSY      = (state_q == DIV);
`ifdef ALU_SEQ_REM_EN
  assign REM_OUT   = rem_q;
`endif
  alu_seq_div #(.DATA_WIDTH(DATA_WIDTH)) u_div (
    .clk    (CLK),
    .rst_n  (RST),
    .start_i(div_start),
    .a_i    (A),
    .b_i    (B),
    .done_o (div_done),
    .div0_o (div0),
    .quot_o (div_quot)
`ifdef ALU_SEQ_REM_EN
    ,
    .rem_o  (div_rem)
`endif
  );
  // Single-cycle units; the DIV entry here only covers the divide-by-zero case
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_d0  = 1'b0;
`ifdef ALU_SEQ_REM_EN
    alu_rem = '0;
`endif
    case (ALU_FUN)
      OP_ADD:  {alu_cy, alu_res} = sum;
      OP_SUB:  begin
        alu_res = A - B;
        alu_cy  = A < B;
      end
      OP_MUL:  alu_res = A * B;
      OP_DIV:  begin
        alu_res = '1;
        alu_d0  = 1'b1;
`ifdef ALU_SEQ_REM_EN
        alu_rem = A;
`endif
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NAND: alu_res = ~(A & B);
      OP_NOR:  alu_res = ~(A | B);
      OP_EQ:   alu_res = (A == B) ? DATA_WIDTH'(1) : '0;
      OP_GT:   alu_res = (A > B) ? DATA_WIDTH'(2) : '0;
      OP_LT:   alu_res = (A < B) ? DATA_WIDTH'(3) : '0;
      OP_SHRA: alu_res = A >> 1;
      OP_SHLA: alu_res = A << 1;
      OP_SHRB: alu_res = B >> 1;
      OP_SHLB: alu_res = B << 1;
      default: alu_res = '0;
    endcase
  end
  // Output register loads on a non-divider accept or divider completion, and drains when the consumer takes it
  always_comb begin
    state_d  = div_start ? DIV : div_done ? IDLE : state_q;
    result_d = result_q;
    cy_d     = cy_q;
    flags_d  = flags_q;
    d0_d     = d0_q;
    valid_d  = valid_q;
`ifdef ALU_SEQ_REM_EN
    rem_d    = rem_q;
`endif
    if (accept && !div_start) begin
      result_d = alu_res;
      cy_d     = alu_cy;
      flags_d  = unit_flags(ALU_FUN[3:2]);
      d0_d     = alu_d0;
      valid_d  = 1'b1;
`ifdef ALU_SEQ_REM_EN
      rem_d    = alu_rem;
`endif
    end else if (div_done) begin
      result_d = div_quot;
      cy_d     = 1'b0;
      flags_d  = unit_flags(UNIT_ARITH);
      d0_d     = 1'b0;
      valid_d  = 1'b1;
`ifdef ALU_SEQ_REM_EN
      rem_d    = div_rem;
`endif
    end else if (OUT_READY) begin
      valid_d  = 1'b0;
    end
  end
  // FSM and registered outputs
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q  <= IDLE;
      result_q <= '0;
      cy_q     <= 1'b0;
      flags_q  <= '0;
      d0_q     <= 1'b0;
      valid_q  <= 1'b0;
`ifdef ALU_SEQ_REM_EN
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cy_q     <= cy_d;
      flags_q  <= flags_d;
      d0_q     <= d0_d;
      valid_q  <= valid_d;
`ifdef ALU_SEQ_REM_EN
      rem_q    <= rem_d;
`endif
    end
endmodule
